spindle_spike_gen: RTL and testbench

Converts the spindle's Ia and II afferent firing rates into spike trains. Rates arrive as IEEE-754 single-precision pulses-per-second values and are converted to fixed point, then integrated per channel on a simulation tick; each channel emits a one-cycle spike pulse when its accumulator crosses threshold. The block sits directly downstream of the spindle, taking its `out3` (Ia_muscle) and `out2` (II_muscle), and feeds spike-driven stages such as motoneuron and synapse models, plus host spike counters.

---
 rtl/spindle_pkg.sv | 26 ++
 rtl/flt2fix_q17_8.sv | 28 ++
 rtl/spindle_spike_gen.sv | 109 ++++++++++
 tb/tb_spindle_spike_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spindle_pkg.sv
// rtl/spindle_pkg.sv - shared constants, FSM state type and accumulator helper for spindle_spike_gen
package spindle_pkg;

  localparam int Q_FRAC = 8;
  localparam int RATE_W = 25;
  localparam logic [RATE_W-1:0] RATE_SAT = 25'h1FF_FFFF;

  // Biased IEEE-754 single exponent bounds for the Q17.8 conversion window
  localparam logic [7:0] EXP_MIN    = 8'd119;
  localparam logic [7:0] EXP_SAT    = 8'd144;
  localparam logic [7:0] EXP_BIAS_Q = 8'd150;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV_IA = 2'd1,
    CONV_II = 2'd2
  } sg_state_t;

  // Residue after a spike, clamped so one tick can never owe a second spike
  function automatic logic [31:0] acc_wrap(input logic [31:0] n, input logic [31:0] thresh);
    logic [31:0] d;
    d = n - thresh;
    return (d > thresh - 32'd1) ? thresh - 32'd1 : d;
  endfunction

endpackage

// File: rtl/flt2fix_q17_8.sv
// rtl/flt2fix_q17_8.sv - IEEE-754 single to unsigned Q17.8 with truncation and saturation
module flt2fix_q17_8
  import spindle_pkg::*;
(
  input  logic [31:0]       flt,
  output logic [RATE_W-1:0] fix
);

  logic [7:0]  expo;
  logic [31:0] mant_q;
  logic [4:0]  rsh;

  // Inside the window exp is 119..143, so only the right-shift path exists (shift 7..31)
  always_comb begin
    expo   = flt[30:23];
    mant_q = {1'b1, flt[22:0], 8'h00};
    rsh    = 5'(EXP_BIAS_Q - expo);
    fix    = '0;
    if (flt[31] || (expo < EXP_MIN)) begin
      fix = '0;
    end else if (expo >= EXP_SAT) begin
      fix = RATE_SAT;
    end else begin
      fix = RATE_W'(mant_q >> rsh);
    end
  end

endmodule

// File: rtl/spindle_spike_gen.sv
// rtl/spindle_spike_gen.sv - converts Ia/II float rates to fixed point and integrates them into spike trains
module spindle_spike_gen
  import spindle_pkg::*;
#(
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rate_valid,
  input  logic [31:0]      ia_rate,
  input  logic [31:0]      ii_rate,
  input  logic             tick,
  input  logic             cnt_clear,
  output logic             spike_ia,
  output logic             spike_ii,
  output logic [CNT_W-1:0] cnt_ia,
  output logic [CNT_W-1:0] cnt_ii,
  output logic             busy
);

  localparam logic [31:0] THRESH = 32'(TICK_HZ) << Q_FRAC;

  sg_state_t         state;
  logic              pend;
  logic [31:0]       hold_ia, hold_ii;
  logic [RATE_W-1:0] rate_ia, rate_ii;
  logic [31:0]       acc_ia, acc_ii;

  logic [31:0]       conv_in;
  logic [RATE_W-1:0] conv_out;
  logic [31:0]       n_ia, n_ii;
  logic              hit_ia, hit_ii;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic clr, input logic spk);
    if (clr) return CNT_W'(spk);
    if (spk && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  assign conv_in = (state == CONV_II) ? hold_ii : hold_ia;

  flt2fix_q17_8 u_f2x (
    .flt (conv_in),
    .fix (conv_out)
  );

  // Rates update on the same edge as a tick, so the tick sees the old rate
  assign n_ia   = acc_ia + 32'(rate_ia);
  assign n_ii   = acc_ii + 32'(rate_ii);
  assign hit_ia = tick & (n_ia >= THRESH);
  assign hit_ii = tick & (n_ii >= THRESH);

  assign busy = pend | (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pend    <= 1'b0;
      hold_ia <= '0;
      hold_ii <= '0;
      rate_ia <= '0;
      rate_ii <= '0;
    end else begin
      if (rate_valid) begin
        hold_ia <= ia_rate;
        hold_ii <= ii_rate;
      end
      // A strobe on the IDLE->CONV_IA edge re-arms pend for another pass
      pend <= rate_valid | (pend & (state != IDLE));
      case (state)
        IDLE: begin
          if (pend) state <= CONV_IA;
        end
        CONV_IA: begin
          rate_ia <= conv_out;
          state   <= CONV_II;
        end
        CONV_II: begin
          rate_ii <= conv_out;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_ia   <= '0;
      acc_ii   <= '0;
      spike_ia <= 1'b0;
      spike_ii <= 1'b0;
      cnt_ia   <= '0;
      cnt_ii   <= '0;
    end else begin
      spike_ia <= hit_ia;
      spike_ii <= hit_ii;
      if (tick) begin
        acc_ia <= hit_ia ? acc_wrap(n_ia, THRESH) : n_ia;
        acc_ii <= hit_ii ? acc_wrap(n_ii, THRESH) : n_ii;
      end
      cnt_ia <= cnt_next(cnt_ia, cnt_clear, hit_ia);
      cnt_ii <= cnt_next(cnt_ii, cnt_clear, hit_ii);
    end
  end

endmodule

// File: tb/tb_spindle_spike_gen.sv
// tb/tb_spindle_spike_gen.sv - self-checking bench for spindle_spike_gen against a rate/accumulator model
module tb_spindle_spike_gen;

  localparam longint THR = 256000;
  localparam longint SAT = 33554431;

  logic        clk = 1'b0;
  logic        reset, rate_valid, tick, cnt_clear;
  logic [31:0] ia_rate, ii_rate;
  logic        spike_ia, spike_ii, busy;
  logic [15:0] cnt_ia, cnt_ii;
  logic        spike_ia4, spike_ii4, busy4;
  logic [3:0]  cnt_ia4, cnt_ii4;

  always #5 clk = ~clk;

  spindle_spike_gen #(.TICK_HZ(1000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rate_valid(rate_valid), .ia_rate(ia_rate), .ii_rate(ii_rate),
    .tick(tick), .cnt_clear(cnt_clear), .spike_ia(spike_ia), .spike_ii(spike_ii),
    .cnt_ia(cnt_ia), .cnt_ii(cnt_ii), .busy(busy));

  spindle_spike_gen #(.TICK_HZ(1000), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .rate_valid(rate_valid), .ia_rate(ia_rate), .ii_rate(ii_rate),
    .tick(tick), .cnt_clear(cnt_clear), .spike_ia(spike_ia4), .spike_ii(spike_ii4),
    .cnt_ia(cnt_ia4), .cnt_ii(cnt_ii4), .busy(busy4));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Real-valued reference: floor(v * 256), negatives to 0, overflow/Inf/NaN saturate
  function automatic longint f2x_model(input logic [31:0] v);
    real    mag;
    int     e;
    int     p;
    e = int'(v[30:23]);
    if (v[31]) return 0;
    if (e == 255) return SAT;
    if (e == 0) return 0;
    mag = 1.0 + real'(v[22:0]) / 8388608.0;
    p = e - 127 + 8;
    if (p >= 0) for (int i = 0; i < p; i++) mag = mag * 2.0;
    else for (int i = 0; i < -p; i++) mag = mag / 2.0;
    if (mag >= 33554432.0) return SAT;
    return longint'($floor(mag));
  endfunction

  longint      m_rate[2], m_acc[2], m_c16[2], m_c4[2], mn;
  logic [31:0] m_hold[2];
  bit          m_spk[2];
  bit          m_pend;
  int          run_age;
  bit          armed = 0;

  // Model: accumulate with pre-edge rates, then advance the conversion timeline
  always @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        m_rate[c] = 0; m_acc[c] = 0; m_c16[c] = 0; m_c4[c] = 0; m_hold[c] = 0; m_spk[c] = 0;
      end
      m_pend = 0;
      run_age = -1;
      armed = 1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_spk[c] = 0;
        if (tick) begin
          mn = m_acc[c] + m_rate[c];
          if (mn >= THR) begin
            m_spk[c] = 1;
            m_acc[c] = (mn - THR > THR - 1) ? THR - 1 : mn - THR;
          end else m_acc[c] = mn;
        end
        if (cnt_clear) begin
          m_c16[c] = m_spk[c];
          m_c4[c]  = m_spk[c];
        end else if (m_spk[c]) begin
          if (m_c16[c] < 65535) m_c16[c]++;
          if (m_c4[c] < 15) m_c4[c]++;
        end
      end
      if (run_age == 0) begin
        m_rate[0] = f2x_model(m_hold[0]);
        run_age = 1;
      end else if (run_age == 1) begin
        m_rate[1] = f2x_model(m_hold[1]);
        run_age = -1;
      end else if (m_pend) begin
        m_pend = 0;
        run_age = 0;
      end
      if (rate_valid) begin
        m_hold[0] = ia_rate;
        m_hold[1] = ii_rate;
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("spike_ia", spike_ia, m_spk[0]);
      check("spike_ii", spike_ii, m_spk[1]);
      check("cnt_ia", cnt_ia, m_c16[0]);
      check("cnt_ii", cnt_ii, m_c16[1]);
      check("busy", busy, (m_pend || run_age >= 0));
      check("rate_ia", dut.rate_ia, m_rate[0]);
      check("rate_ii", dut.rate_ii, m_rate[1]);
      check("acc_ia", dut.acc_ia, m_acc[0]);
      check("acc_ii", dut.acc_ii, m_acc[1]);
      check("spike_ia4", spike_ia4, m_spk[0]);
      check("cnt_ia4", cnt_ia4, m_c4[0]);
      check("cnt_ii4", cnt_ii4, m_c4[1]);
      check("busy4", busy4, (m_pend || run_age >= 0));
      check("spike_ii4", spike_ii4, m_spk[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] a, input logic [31:0] b);
    ia_rate = a;
    ii_rate = b;
    rate_valid = 1;
    cyc();
    rate_valid = 0;
  endtask

  int first, n_ia, n_ii;

  initial begin
    reset = 0; rate_valid = 0; tick = 0; cnt_clear = 0; ia_rate = 0; ii_rate = 0;

    check("m_100", f2x_model(32'h42C8_0000), 25600);
    check("m_inf", f2x_model(32'h7F80_0000), SAT);
    check("m_nan", f2x_model(32'h7FC0_0000), SAT);
    check("m_neg", f2x_model(32'hC0A0_0000), 0);
    check("m_negz", f2x_model(32'h8000_0000), 0);
    check("m_den", f2x_model(32'h0000_0001), 0);
    check("m_2m9", f2x_model(32'h3B00_0000), 0);
    check("m_2m8", f2x_model(32'h3B80_0000), 1);
    check("m_e143", f2x_model(32'h47FF_FFFF), 33554430);
    check("m_e144", f2x_model(32'h4800_0000), SAT);

    cyc(); cyc();
    reset = 1;
    cyc();
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt_ia, 0);

    // 100 pps: spike every 10th tick, 100 spikes in 1000 ticks
    strobe(32'h42C8_0000, 32'h0000_0000);
    repeat (4) cyc();
    check("t1_rate", dut.rate_ia, 25600);
    first = 0;
    tick = 1;
    for (int i = 1; i <= 1000; i++) begin
      cyc();
      if (spike_ia && first == 0) first = i;
    end
    tick = 0;
    cyc();
    check("t1_first", first, 10);
    check("t1_cnt", cnt_ia, 100);
    check("t1_cnt4", cnt_ia4, 15);

    // Negative, denormal and sub-LSB II rates all convert to zero
    strobe(32'h3B80_0000, 32'hC0A0_0000);
    repeat (4) cyc();
    check("t2_ia", dut.rate_ia, 1);
    check("t2_neg", dut.rate_ii, 0);
    strobe(32'h3B80_0000, 32'h0000_0001);
    repeat (4) cyc();
    check("t2_den", dut.rate_ii, 0);
    strobe(32'h3B80_0000, 32'h3B00_0000);
    repeat (4) cyc();
    check("t2_small", dut.rate_ii, 0);
    n_ii = 0;
    tick = 1;
    repeat (500) begin
      cyc();
      if (spike_ii) n_ii++;
    end
    tick = 0;
    check("t2_nospk", n_ii, 0);

    // Exponent window edges, then Inf/NaN force a spike on every tick
    strobe(32'h47FF_FFFF, 32'h4800_0000);
    repeat (4) cyc();
    check("t3_e143", dut.rate_ia, 33554430);
    check("t3_e144", dut.rate_ii, SAT);
    strobe(32'h7F80_0000, 32'h7FC0_0000);
    repeat (4) cyc();
    check("t3_inf", dut.rate_ia, SAT);
    check("t3_nan", dut.rate_ii, SAT);
    n_ia = 0; n_ii = 0;
    tick = 1;
    repeat (50) begin
      cyc();
      if (spike_ia) n_ia++;
      if (spike_ii) n_ii++;
    end
    tick = 0;
    check("t3_spk_ia", n_ia, 50);
    check("t3_spk_ii", n_ii, 50);
    check("t3_accmax", dut.acc_ia, 255999);

    // Back-to-back strobes: last wins; a tick mid-conversion uses the old rate
    ia_rate = 32'h4348_0000; ii_rate = 32'h4120_0000; rate_valid = 1;
    cyc();
    ia_rate = 32'h0000_0000; ii_rate = 32'h8000_0000;
    cyc();
    check("t4_busy", busy, 1);
    rate_valid = 0;
    tick = 1;
    cyc();
    check("t4_oldrate", spike_ia, 1);
    tick = 0;
    repeat (6) cyc();
    check("t4_rate_ia", dut.rate_ia, 0);
    check("t4_rate_ii", dut.rate_ii, 0);
    check("t4_idle", busy, 0);

    // 4-bit counter saturation and clear interaction
    cnt_clear = 1;
    cyc();
    cnt_clear = 0;
    check("t5_clr0", cnt_ia4, 0);
    strobe(32'h7F80_0000, 32'h0000_0000);
    repeat (4) cyc();
    tick = 1;
    repeat (20) cyc();
    check("t5_sat4", cnt_ia4, 15);
    check("t5_cnt16", cnt_ia, 20);
    cnt_clear = 1;
    cyc();
    check("t5_clrspk", cnt_ia4, 1);
    tick = 0;
    cyc();
    check("t5_clr", cnt_ia4, 0);
    cnt_clear = 0;

    // Reset while in CONV_IA abandons the conversion
    strobe(32'h42C8_0000, 32'h42C8_0000);
    cyc();
    reset = 0;
    cyc();
    check("t6_spk", spike_ia, 0);
    check("t6_cnt", cnt_ia, 0);
    check("t6_busy", busy, 0);
    check("t6_rate", dut.rate_ia, 0);
    reset = 1;
    n_ia = 0; n_ii = 0;
    tick = 1;
    repeat (30) begin
      cyc();
      if (spike_ia) n_ia++;
      if (spike_ii) n_ii++;
    end
    tick = 0;
    cyc();
    check("t6_nospk_ia", n_ia, 0);
    check("t6_nospk_ii", n_ii, 0);
    check("t6_rate_after", dut.rate_ia, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
